// File: rtl/dmem_arbiter_pkg.sv
// Shared configuration for the data-memory arbiter: widths, depth, state encoding
// and the bounds-check switch controlled by DMEM_ARB_BOUNDS_EN.
`ifndef DMEM_DATA_W
`define DMEM_DATA_W 16
`endif
`ifndef DMEM_ADDR_W
`define DMEM_ADDR_W 16
`endif
`ifndef DMEM_DEPTH
`define DMEM_DEPTH 8
`endif

package dmem_arbiter_pkg;

  localparam int DMEM_DATA_W_DEF = `DMEM_DATA_W;
  localparam int DMEM_ADDR_W_DEF = `DMEM_ADDR_W;
  localparam int DMEM_DEPTH_DEF  = `DMEM_DEPTH;

`ifdef DMEM_ARB_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } arb_state_e;

  // One-hot pick between two eligible ports; ptr=0 favours port 0 on a tie.
  function automatic logic [1:0] rr_pick(input logic [1:0] elig, input logic ptr);
    logic [1:0] grant;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    return grant;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker; the pointer only moves when both ports contend,
// so it always ends up favouring the port that lost the last tie.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_elig,
  input  logic       i_adv,
  output logic [1:0] o_grant
);

  logic r_ptr;

  assign o_grant = rr_pick(i_elig, r_ptr);

  // Pointer register: after a tie, favour the port that was not granted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_adv) begin
      r_ptr <= o_grant[0];
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8-word data memory between two requesters.
// Optional bounds checking is enabled by defining DMEM_ARB_BOUNDS_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W_DEF,
  parameter int ADDR_W = DMEM_ADDR_W_DEF,
  parameter int DEPTH  = DMEM_DEPTH_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic                r_ack0, r_ack1, r_err, r_mem_we, r_mem_re;
  logic [DATA_W-1:0]   r_rdata, r_mem_wdata;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_we, r_id, r_oob;

  logic                w_ack0_nxt, w_ack1_nxt, w_err_nxt, w_mem_we_nxt, w_mem_re_nxt;
  logic [DATA_W-1:0]   w_rdata_nxt, w_mem_wdata_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic                w_we_nxt, w_id_nxt, w_oob_nxt;

  logic                w_idle;
  logic [1:0]          w_elig;
  logic [1:0]          w_grant;
  logic                w_adv;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_sel_oob;

  // A port whose ack is high this cycle still shows its old req, so it sits out.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_elig      = {i_req1 & ~r_ack1, i_req0 & ~r_ack0} & {2{w_idle}};
  assign w_adv       = w_elig[0] & w_elig[1];
  assign w_sel_we    = w_grant[1] ? i_we1    : i_we0;
  assign w_sel_addr  = w_grant[1] ? i_addr1  : i_addr0;
  assign w_sel_wdata = w_grant[1] ? i_wdata1 : i_wdata0;
  assign w_sel_oob   = BOUNDS_EN & (w_sel_addr >= ADDR_W'(DEPTH));

  rr_arb2 u_rr_arb2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_elig  (w_elig),
    .i_adv   (w_adv),
    .o_grant (w_grant)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: ACCESS always lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (|w_grant) begin
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: memory pins are loaded on the grant edge so they are live for the ACCESS cycle.
  always_comb begin
    w_ack0_nxt      = 1'b0;
    w_ack1_nxt      = 1'b0;
    w_rdata_nxt     = r_rdata;
    w_err_nxt       = r_err;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_we_nxt    = 1'b0;
    w_mem_re_nxt    = 1'b0;
    w_we_nxt        = r_we;
    w_id_nxt        = r_id;
    w_oob_nxt       = r_oob;
    case (r_state)
      ST_IDLE: begin
        if (|w_grant) begin
          w_mem_addr_nxt  = w_sel_addr;
          w_mem_wdata_nxt = w_sel_wdata;
          w_mem_we_nxt    = w_sel_we & ~w_sel_oob;
          w_mem_re_nxt    = ~w_sel_we & ~w_sel_oob;
          w_we_nxt        = w_sel_we;
          w_id_nxt        = w_grant[1];
          w_oob_nxt       = w_sel_oob;
        end else begin
          w_mem_we_nxt    = 1'b0;
          w_mem_re_nxt    = 1'b0;
        end
      end
      ST_ACCESS: begin
        w_ack0_nxt  = ~r_id;
        w_ack1_nxt  = r_id;
        w_rdata_nxt = (r_we | r_oob) ? {DATA_W{1'b0}} : i_mem_rdata;
        w_err_nxt   = r_oob;
      end
      default: begin
        w_ack0_nxt = 1'b0;
        w_ack1_nxt = 1'b0;
      end
    endcase
  end

  // Output and latched-request registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_rdata     <= {DATA_W{1'b0}};
      r_err       <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_we        <= 1'b0;
      r_id        <= 1'b0;
      r_oob       <= 1'b0;
    end else begin
      r_ack0      <= w_ack0_nxt;
      r_ack1      <= w_ack1_nxt;
      r_rdata     <= w_rdata_nxt;
      r_err       <= w_err_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_re    <= w_mem_re_nxt;
      r_we        <= w_we_nxt;
      r_id        <= w_id_nxt;
      r_oob       <= w_oob_nxt;
    end
  end

  assign o_ack0      = r_ack0;
  assign o_ack1      = r_ack1;
  assign o_rdata     = r_rdata;
  assign o_err       = r_err;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_we    = r_mem_we;
  assign o_mem_re    = r_mem_re;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 8-word RAM; expectations follow
// DMEM_ARB_BOUNDS_EN when it is defined.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_BOUNDS_EN
  localparam bit BND = 1'b1;
`else
  localparam bit BND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err, mem_we, mem_re;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [15:0] mem [0:7] = '{default: 16'h0000};
  int          we_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          we_base;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req0      (req0),
    .i_req1      (req1),
    .i_we0       (we0),
    .i_we1       (we1),
    .i_addr0     (addr0),
    .i_addr1     (addr1),
    .i_wdata0    (wdata0),
    .i_wdata1    (wdata1),
    .o_ack0      (ack0),
    .o_ack1      (ack1),
    .o_rdata     (rdata),
    .o_err       (err),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_we    (mem_we),
    .o_mem_re    (mem_re),
    .i_mem_rdata (mem_rdata)
  );

  // RAM model: synchronous write, combinational read gated by re.
  assign mem_rdata = mem_re ? mem[mem_addr[2:0]] : 16'h0000;
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[2:0]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0000; addr1 = 16'h0000; wdata0 = 16'h0000; wdata1 = 16'h0000;

    // 1. reset
    repeat (3) cyc();
    chk("rst_acks", {30'd0, ack1, ack0}, 32'd0);
    chk("rst_rdata_err", {15'd0, err, rdata}, 32'd0);
    chk("rst_mem_pins", {mem_we, mem_re, mem_addr, 14'd0}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_no_ack", {28'd0, mem_we, mem_re, ack1, ack0}, 32'd0);
    end

    // 2. port 0 write then read of addr 3
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'd3; wdata0 = 16'hA5C3;
    cyc();
    chk("wr_access_pins", {mem_we, mem_re, ack0, 13'd0, mem_addr}, {3'b100, 13'd0, 16'd3});
    chk("wr_access_wdata", {16'd0, mem_wdata}, 32'h0000A5C3);
    cyc();
    chk("wr_ack0", {29'd0, err, ack1, ack0}, 32'd1);
    chk("wr_mem_we_off", {31'd0, mem_we}, 32'd0);
    req0 = 1'b0;
    cyc();
    chk("wr_ack_pulse", {31'd0, ack0}, 32'd0);
    chk("wr_mem3", {16'd0, mem[3]}, 32'h0000A5C3);
    req0 = 1'b1; we0 = 1'b0;
    cyc();
    chk("rd_access_re", {30'd0, mem_we, mem_re}, 32'd1);
    cyc();
    chk("rd_ack0", {30'd0, ack1, ack0}, 32'd1);
    chk("rd_data", {16'd0, rdata}, 32'h0000A5C3);
    req0 = 1'b0;
    cyc();
    chk("rd_ack_pulse", {31'd0, ack0}, 32'd0);

    // 3. contention on addr 1: both held, strict alternation 0,1,0,1
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'd1; wdata0 = 16'h1111;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'd1; wdata1 = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("cont_grant_wdata", {13'd0, ack1, ack0, mem_we, mem_wdata},
          {13'd0, 3'b001, ((i % 2) == 1) ? 16'h2222 : 16'h1111});
      cyc();
      chk("cont_ack_order", {30'd0, ack1, ack0}, ((i % 2) == 1) ? 32'd2 : 32'd1);
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc();
    chk("cont_quiet", {29'd0, mem_we, ack1, ack0}, 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'd1;
    repeat (2) cyc();
    chk("cont_last_writer", {15'd0, ack0, rdata}, {15'd0, 1'b1, 16'h2222});
    req0 = 1'b0;
    cyc();

    // 4. stale req1 held through its ack cycle
    we_base = we_cnt;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'd5; wdata1 = 16'h5555;
    repeat (2) cyc();
    chk("stale_ack1", {30'd0, ack1, ack0}, 32'd2);
    cyc();
    chk("stale_no_regrant", {29'd0, mem_we, ack1, ack0}, 32'd0);
    req1 = 1'b0;
    cyc();
    chk("stale_still_idle", {29'd0, mem_we, ack1, ack0}, 32'd0);
    chk("stale_one_write", we_cnt - we_base, 32'd1);
    chk("stale_mem5", {16'd0, mem[5]}, 32'h00005555);

    // rr pointer favours port 1 after the earlier tie
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'd3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'd1;
    cyc();
    chk("rr_first_p1", {15'd0, mem_re, mem_addr}, {15'd0, 1'b1, 16'd1});
    cyc();
    chk("rr_ack1_data", {14'd0, ack1, ack0, rdata}, {14'd0, 2'b10, 16'h2222});
    req1 = 1'b0;
    cyc();
    chk("rr_then_p0", {15'd0, mem_re, mem_addr}, {15'd0, 1'b1, 16'd3});
    cyc();
    chk("rr_ack0_data", {14'd0, ack1, ack0, rdata}, {14'd0, 2'b01, 16'hA5C3});
    req0 = 1'b0;
    cyc();

    // 5. reset during a read ACCESS
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'd3;
    cyc();
    chk("rstmid_re_on", {31'd0, mem_re}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_re_drop", {30'd0, mem_re, ack0}, 32'd0);
    req0 = 1'b0;
    repeat (2) cyc();
    chk("rstmid_no_ack", {30'd0, ack1, ack0}, 32'd0);
    rst_n = 1'b1;
    cyc();
    req0 = 1'b1;
    repeat (2) cyc();
    chk("rstmid_recover", {15'd0, ack0, rdata}, {15'd0, 1'b1, 16'hA5C3});
    req0 = 1'b0;
    cyc();

    // 6. out-of-range address 8 (write) and 9 (read)
    we_base = we_cnt;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'd8; wdata0 = 16'h1234;
    cyc();
    chk("bnd_wr_we", {31'd0, mem_we}, BND ? 32'd0 : 32'd1);
    cyc();
    chk("bnd_wr_ack", {14'd0, ack0, err, rdata}, {14'd0, 1'b1, BND, 16'h0000});
    req0 = 1'b0;
    cyc();
    chk("bnd_wr_count", we_cnt - we_base, BND ? 32'd0 : 32'd1);
    chk("bnd_mem0", {16'd0, mem[0]}, BND ? 32'h00000000 : 32'h00001234);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'd9;
    cyc();
    chk("bnd_rd_re", {31'd0, mem_re}, BND ? 32'd0 : 32'd1);
    cyc();
    chk("bnd_rd_ack", {14'd0, ack0, err, rdata}, {14'd0, 1'b1, BND, BND ? 16'h0000 : 16'h2222});
    req0 = 1'b0;
    cyc();
    chk("bnd_final_idle", {30'd0, ack1, ack0}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port 16-bit data memory (8-word RAM, synchronous write, combinational gated read).
- Shares the memory between requester 0 (core load/store unit) and requester 1 (debug/DMA loader) using round-robin arbitration and a req/ack handshake.
- Registers the read data and drives the memory's addr/wdata/we/re pins.
- Sits between the pipeline MEM stage and the data memory.

Parameters:
- DATA_W, 16, data width of requesters and memory
- ADDR_W, 16, requester address width
- DEPTH, 8, number of memory words; index = addr[$clog2(DEPTH)-1:0]

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  access request, held high until the matching ack
- we0 / we1  in  1  1 = write, 0 = read; sampled with req
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read result, valid while ack0 or ack1 is high
- err  out  1  bounds error, valid with ack
- mem_addr  out  ADDR_W  to data memory
- mem_wdata  out  DATA_W  to data memory
- mem_we  out  1  to data memory
- mem_re  out  1  to data memory
- mem_rdata  in  DATA_W  from data memory

Behaviour:
- Reset values: state=IDLE, rr pointer=0 (port 0 favoured first), ack0=ack1=0, rdata=0, err=0, mem_we=mem_re=0, mem_addr=mem_wdata=0.
- FSM states: IDLE and ACCESS.
- IDLE:
  - Eligible requester: reqN=1 and ackN=0. A requester whose ack is high this cycle is ignored, because its req is stale.
  - One eligible: grant it.
  - Both eligible: grant the port the rr pointer favours, then set the pointer to favour the other port.
  - On the grant edge: latch addr/wdata/we and the granted id, go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr/mem_wdata come from the latched values; mem_we=latched we; mem_re=~latched we.
  - On the exiting edge: a write commits in memory; rdata <= mem_rdata for a read, rdata <= 0 for a write; ack of the granted id <= 1; return to IDLE.
- Outside ACCESS: mem_we=mem_re=0 and mem_addr/mem_wdata hold their last values.
- Latency: req high at edge T -> ack high during cycle T+2. Throughput is one access per 2 cycles while req is held and alternated.
- Ack is a one-cycle pulse. The requester must drop req, or present a new request, in the ack cycle. A new request is accepted no earlier than the edge after ack falls.
- Simultaneous requests alternate strictly 0,1,0,1 under the rr pointer.
- Address wrap: addresses >= DEPTH alias to addr mod DEPTH, unless the optional feature is enabled.
- Reset asserted during ACCESS: state, ack and mem_we/mem_re clear immediately and no ack is issued. A write coincident with the reset edge is undefined in memory.

Optional Feature:
- Macro: DMEM_ARB_BOUNDS_EN.
- Defined: a granted access with addr >= DEPTH still spends one ACCESS cycle, but mem_we=mem_re=0. The ack carries err=1 and rdata=0; memory is unchanged.
- Undefined: no bounds check, err tied 0, addresses alias.

Decomposition:
- Shared package/include: DATA_W/ADDR_W/DEPTH defaults (with the existing width/depth defines) and the IDLE/ACCESS state encoding.
- One sub-module, rr_arb2: a 2-input round-robin picker holding the pointer flop. Inputs: eligible vector, advance strobe. Outputs: one-hot grant.

Test Plan:
1. Reset: hold rst_n=0 3 cycles, then release -> all outputs 0, state IDLE; ack never pulses with no req.
2. Single write/read on port 0: write addr=3, wdata=16'hA5C3 -> ack0 at T+2, err=0. Then read addr=3 -> ack0 at T+2 with rdata=16'hA5C3.
3. Contention: req0 and req1 both held, both writing to addr 1 with 16'h1111/16'h2222 -> grants order 0,1,0,1, acks every 2 cycles, never both in one cycle. Final read of addr 1 returns the last writer's value.
4. Stale-req guard: port 1 keeps req1 high one cycle after ack1 -> no second grant for port 1 from that stale cycle; exactly one write observed on mem_we.
5. Reset mid-op: assert rst_n=0 during ACCESS of a read -> ack0 stays 0, mem_re drops the same cycle; after release, a new request completes normally.
6. Bounds: access addr=8. With DMEM_ARB_BOUNDS_EN: ack with err=1, rdata=0, no mem_we pulse. Without it: the write lands in word 0, err=0.
